// File: rtl/wb_rr_intercon.sv
// Shared-bus Wishbone interconnect: round-robin arbitration over N masters,
// base/mask address decode to M slaves, default-slave err and a stall watchdog.
module wb_rr_intercon #(
    parameter int unsigned              n_masters  = 4,
    parameter int unsigned              n_slaves   = 4,
    parameter logic [32*n_slaves-1:0]   slave_base = '0,
    parameter logic [32*n_slaves-1:0]   slave_mask = '0,
    parameter int unsigned              timeout    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [32*n_masters-1:0]   m_adr_i,
    input  logic [32*n_masters-1:0]   m_dat_i,
    input  logic [4*n_masters-1:0]    m_sel_i,
    input  logic [n_masters-1:0]      m_we_i,
    input  logic [n_masters-1:0]      m_cyc_i,
    input  logic [n_masters-1:0]      m_stb_i,
    output logic [31:0]               m_dat_o,
    output logic [n_masters-1:0]      m_ack_o,
    output logic [n_masters-1:0]      m_err_o,
    output logic [n_masters-1:0]      m_rty_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [n_slaves-1:0]       s_cyc_o,
    output logic [n_slaves-1:0]       s_stb_o,
    input  logic [32*n_slaves-1:0]    s_dat_i,
    input  logic [n_slaves-1:0]       s_ack_i,
    input  logic [n_slaves-1:0]       s_err_i,
    input  logic [n_slaves-1:0]       s_rty_i
);

    localparam int MW = (n_masters > 1) ? $clog2(n_masters) : 1;
    localparam int SW = (n_slaves > 1) ? $clog2(n_slaves) : 1;
    localparam bit WD_EN = (timeout != 0);
    localparam logic [15:0] WD_LAST = (timeout == 0) ? 16'd0 : 16'(timeout - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   grant_q, grant_d;
    logic [MW-1:0]   rr_q, rr_d;
    logic [15:0]     wdog_q, wdog_d;
    logic            derr_q, derr_d;

    logic [MW-1:0]   pick;
    int              idx;

    logic            busy;
    logic [31:0]     g_adr, g_dat;
    logic [3:0]      g_sel;
    logic            g_we, g_cyc, g_stb;
    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic            h_ack, h_err, h_rty;
    logic            wd_fire, resp_any;

    // First requester at or after the round-robin pointer.
    always_comb begin
        pick = rr_q;
        idx  = 0;
        for (int i = int'(n_masters) - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % int'(n_masters);
            if (m_cyc_i[idx]) pick = MW'(idx);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d = BUSY;
                    grant_d = pick;
                end
            end
            BUSY: begin
                if (!m_cyc_i[grant_q]) begin
                    state_d = IDLE;
                    rr_d    = MW'((int'(grant_q) + 1) % int'(n_masters));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == BUSY);
        g_adr = busy ? m_adr_i[32*grant_q +: 32] : 32'd0;
        g_dat = busy ? m_dat_i[32*grant_q +: 32] : 32'd0;
        g_sel = busy ? m_sel_i[4*grant_q +: 4] : 4'd0;
        g_we  = busy & m_we_i[grant_q];
        g_cyc = busy & m_cyc_i[grant_q];
        g_stb = g_cyc & m_stb_i[grant_q];
    end

    // Lowest slave index wins when windows overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(n_slaves) - 1; i >= 0; i--) begin
            if ((g_adr & slave_mask[32*i +: 32]) == slave_base[32*i +: 32]) begin
                hit     = busy;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        h_ack    = hit & s_ack_i[hit_idx];
        h_err    = hit & s_err_i[hit_idx];
        h_rty    = hit & s_rty_i[hit_idx];
        wd_fire  = WD_EN & g_stb & (wdog_q == WD_LAST);
        resp_any = h_ack | h_err | h_rty | derr_q;
    end

    always_comb begin
        wdog_d = '0;
        if (WD_EN && g_stb && !resp_any && !wd_fire) wdog_d = wdog_q + 16'd1;
        derr_d = g_stb & ~hit & ~derr_q;
    end

    always_comb begin
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        s_sel_o = g_sel;
        s_we_o  = g_we;
        s_cyc_o = '0;
        s_stb_o = '0;
        m_dat_o = 32'd0;
        if (hit) begin
            s_cyc_o[hit_idx] = g_cyc;
            s_stb_o[hit_idx] = g_stb & ~wd_fire;
            m_dat_o          = s_dat_i[32*hit_idx +: 32];
        end
    end

    // Watchdog err overrides a coincident ack or retry.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (busy) begin
            m_ack_o[grant_q] = h_ack & ~wd_fire;
            m_rty_o[grant_q] = h_rty & ~wd_fire;
            m_err_o[grant_q] = h_err | derr_q | wd_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            wdog_q  <= '0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wdog_q  <= wdog_d;
            derr_q  <= derr_d;
        end
    end

endmodule
